// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - MMIO-mapped 8N1 UART transmitter with TX FIFO and status register
module mmio_uart_tx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_enable,
   input  logic        mmio_sel,
   input  logic        reg_sel,
   input  logic        mem_we,
   input  logic [31:0] data_in,
   output logic [31:0] read_data,
   output logic        uart_tx,
   output logic        tx_irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t        state, state_nxt;
   logic [15:0]   baud_cnt, baud_cnt_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [7:0]    shift_reg, shift_reg_nxt;

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;

   logic          pop;
   logic          push_req;
   logic          push_ok;
   logic          ovf_clr;
   logic          busy, full, empty;
   logic [31:0]   status_word;
   logic          unused_data_bits;

   // A push is only refused when the FIFO is full and the shifter is not draining a slot this edge.
   assign push_req = clk_enable & mmio_sel & mem_we & ~reg_sel;
   assign push_ok  = push_req & ((count < DEPTH_C) | pop);
   assign ovf_clr  = clk_enable & mmio_sel & mem_we & reg_sel & data_in[2];

   assign busy        = (state != S_IDLE);
   assign full        = (count == DEPTH_C);
   assign empty       = (count == '0);
   assign status_word = {21'd0, 7'(count), empty, overflow, full, busy};
   assign tx_irq      = empty & (state == S_IDLE);

   assign unused_data_bits = ^data_in[31:8];

   // Registered MMIO read port: one enabled cycle of latency, frozen while the pipeline stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read_data <= 32'd0;
      end else if (clk_enable) begin
         read_data <= (mmio_sel & reg_sel) ? status_word : 32'd0;
      end
   end

   // FIFO storage has no reset; validity is tracked by count and the pointers.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr] <= data_in[7:0];
      end
   end

   // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow: set by a dropped byte, cleared by a STATUS write with bit 2 set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (push_req & ~push_ok) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

   // Shifter state register; free-running, not gated by the pipeline enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         baud_cnt  <= 16'd0;
         bit_idx   <= 3'd0;
         shift_reg <= 8'd0;
      end else begin
         state     <= state_nxt;
         baud_cnt  <= baud_cnt_nxt;
         bit_idx   <= bit_idx_nxt;
         shift_reg <= shift_reg_nxt;
      end
   end

   // Shifter next-state and line drive; the line is decoded from state so reset forces it high at once.
   always_comb begin
      state_nxt     = state;
      baud_cnt_nxt  = baud_cnt;
      bit_idx_nxt   = bit_idx;
      shift_reg_nxt = shift_reg;
      pop           = 1'b0;
      uart_tx       = 1'b1;
      case (state)
         S_IDLE: begin
            if (count != '0) begin
               pop           = 1'b1;
               shift_reg_nxt = fifo_mem[rd_ptr];
               baud_cnt_nxt  = 16'd0;
               bit_idx_nxt   = 3'd0;
               state_nxt     = S_START;
            end
         end
         S_START: begin
            uart_tx = 1'b0;
            if (baud_cnt == BAUD_LAST) begin
               baud_cnt_nxt = 16'd0;
               bit_idx_nxt  = 3'd0;
               state_nxt    = S_DATA;
            end else begin
               baud_cnt_nxt = baud_cnt + 16'd1;
            end
         end
         S_DATA: begin
            uart_tx = shift_reg[0];
            if (baud_cnt == BAUD_LAST) begin
               baud_cnt_nxt  = 16'd0;
               shift_reg_nxt = {1'b0, shift_reg[7:1]};
               bit_idx_nxt   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_nxt = S_STOP;
               end
            end else begin
               baud_cnt_nxt = baud_cnt + 16'd1;
            end
         end
         S_STOP: begin
            uart_tx = 1'b1;
            if (baud_cnt == BAUD_LAST) begin
               baud_cnt_nxt = 16'd0;
               state_nxt    = S_IDLE;
            end else begin
               baud_cnt_nxt = baud_cnt + 16'd1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_enable;
   logic        mmio_sel;
   logic        reg_sel;
   logic        mem_we;
   logic [31:0] data_in;
   logic [31:0] read_data;
   logic        uart_tx;
   logic        tx_irq;

   always #5 clk = ~clk;

   mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .clk_enable (clk_enable),
      .mmio_sel   (mmio_sel),
      .reg_sel    (reg_sel),
      .mem_we     (mem_we),
      .data_in    (data_in),
      .read_data  (read_data),
      .uart_tx    (uart_tx),
      .tx_irq     (tx_irq)
   );

   int n_pass  = 0;
   int n_total = 0;
   int frames_started = 0;
   int frames_done    = 0;

   // Reference model: queue of waiting bytes, remaining cycles of the frame on the wire,
   // sticky overflow, expected read word, and bytes owed to the line.
   logic [7:0]  fifo_q [$];
   logic [7:0]  line_q [$];
   int          busy_left;
   bit          ovf_m;
   logic [31:0] rd_m;

   typedef struct {
      bit          ce;
      bit          sel;
      bit          rs;
      bit          we;
      logic [31:0] d;
      logic [31:0] exp_rd;
      bit          exp_irq;
      bit          exp_tx;
   } vec_t;

   vec_t vec [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   function automatic logic [31:0] status_m();
      logic [31:0] w;
      w    = 32'(fifo_q.size()) << 4;
      w[3] = (fifo_q.size() == 0);
      w[2] = ovf_m;
      w[1] = (fifo_q.size() == DEPTH);
      w[0] = (busy_left > 0);
      return w;
   endfunction

   task automatic model_reset();
      fifo_q.delete();
      line_q.delete();
      busy_left = 0;
      ovf_m     = 1'b0;
      rd_m      = 32'd0;
   endtask

   // One bus cycle: drive at the negedge, advance the model at the posedge, compare at the next negedge.
   task automatic step(input bit ce, input bit sel, input bit rs, input bit we, input logic [31:0] d);
      logic [31:0] st;
      bit pop_m;
      bit push_m;
      clk_enable = ce;
      mmio_sel   = sel;
      reg_sel    = rs;
      mem_we     = we;
      data_in    = d;
      st     = status_m();
      pop_m  = (busy_left == 0) && (fifo_q.size() > 0);
      push_m = ce && sel && we && !rs;
      @(posedge clk);
      if (ce) rd_m = (sel && rs) ? st : 32'd0;
      if (ce && sel && we && rs && d[2]) ovf_m = 1'b0;
      if (pop_m) begin
         line_q.push_back(fifo_q.pop_front());
         busy_left = 10 * CPB;
      end else if (busy_left > 0) begin
         busy_left--;
      end
      if (push_m) begin
         if (fifo_q.size() < DEPTH) fifo_q.push_back(d[7:0]);
         else ovf_m = 1'b1;
      end
      @(negedge clk);
      chk("read_data", read_data, rd_m);
      chk("tx_irq", tx_irq, (fifo_q.size() == 0) && (busy_left == 0));
      if (busy_left == 0) chk("idle_line", uart_tx, 1);
   endtask

   task automatic drain(input string tag);
      int g = 0;
      while ((fifo_q.size() != 0 || busy_left != 0) && g < 3000) begin
         step(1, 0, 0, 0, 32'd0);
         g++;
      end
      step(1, 0, 0, 0, 32'd0);
      step(1, 0, 0, 0, 32'd0);
      chk({tag, "_drained"}, (fifo_q.size() == 0) && (busy_left == 0), 1);
      chk({tag, "_line_q"}, line_q.size(), 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("reset_async_tx", uart_tx, 1);
      chk("reset_async_irq", tx_irq, 1);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("reset_hold_rd", read_data, 0);
      rst = 1'b0;
   endtask

   // Line decoder: checks frame shape sample by sample and the byte against the model's line queue.
   initial begin : line_monitor
      logic [7:0] b;
      bit shape_ok;
      bit aborted;
      int bi;
      forever begin
         @(negedge clk);
         if (!rst && uart_tx === 1'b0) begin
            frames_started++;
            shape_ok = 1'b1;
            aborted  = 1'b0;
            b        = 8'd0;
            for (int s = 1; s < 10 * CPB; s++) begin
               @(negedge clk);
               if (rst) begin
                  aborted = 1'b1;
                  break;
               end
               bi = s / CPB;
               if (bi == 0) begin
                  if (uart_tx !== 1'b0) shape_ok = 1'b0;
               end else if (bi <= 8) begin
                  if (s % CPB == 0) b[bi-1] = uart_tx;
                  else if (uart_tx !== b[bi-1]) shape_ok = 1'b0;
               end else begin
                  if (uart_tx !== 1'b1) shape_ok = 1'b0;
               end
            end
            if (!aborted) begin
               frames_done++;
               chk("frame_shape", shape_ok, 1);
               if (line_q.size() == 0) chk("frame_unexpected", line_q.size(), 1);
               else chk("frame_byte", b, line_q.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      int base;
      bit r_ce, r_sel, r_rs, r_we;

      rst        = 1'b1;
      clk_enable = 1'b0;
      mmio_sel   = 1'b0;
      reg_sel    = 1'b0;
      mem_we     = 1'b0;
      data_in    = 32'd0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_read_data", read_data, 0);
      chk("reset_uart_tx", uart_tx, 1);
      chk("reset_tx_irq", tx_irq, 1);
      rst = 1'b0;

      //           ce sel rs we data          exp_rd  irq tx
      vec[0] = '{1, 1, 1, 0, 32'h0000_0000, 32'h8,  1, 1};
      vec[1] = '{1, 0, 1, 0, 32'h0000_0000, 32'h0,  1, 1};
      vec[2] = '{1, 1, 0, 0, 32'h0000_0000, 32'h0,  1, 1};
      vec[3] = '{1, 1, 1, 0, 32'h0000_0000, 32'h8,  1, 1};
      vec[4] = '{0, 1, 0, 1, 32'h0000_00A5, 32'h8,  1, 1};
      vec[5] = '{1, 1, 1, 0, 32'h0000_0000, 32'h8,  1, 1};
      vec[6] = '{1, 1, 0, 1, 32'hFFFF_FFA5, 32'h0,  0, 1};
      vec[7] = '{1, 1, 1, 0, 32'h0000_0000, 32'h10, 0, 0};
      vec[8] = '{1, 1, 1, 0, 32'h0000_0000, 32'h9,  0, 0};
      vec[9] = '{1, 1, 1, 1, 32'h0000_0004, 32'h9,  0, 0};
      for (int i = 0; i < 10; i++) begin
         step(vec[i].ce, vec[i].sel, vec[i].rs, vec[i].we, vec[i].d);
         chk($sformatf("vec%0d_rd", i), read_data, vec[i].exp_rd);
         chk($sformatf("vec%0d_irq", i), tx_irq, vec[i].exp_irq);
         chk($sformatf("vec%0d_tx", i), uart_tx, vec[i].exp_tx);
      end
      repeat (45) step(1, 0, 0, 0, 32'd0);
      chk("a5_frames", frames_done, 1);
      chk("a5_irq_after", tx_irq, 1);

      // Overflow with one character in flight: 8 queue, 2 drop.
      base = frames_done;
      step(1, 1, 0, 1, $urandom);
      for (int i = 0; i < 10; i++) step(1, 1, 0, 1, $urandom);
      step(1, 1, 1, 0, 32'd0);
      chk("ovf_status", read_data, 32'h87);
      step(1, 1, 1, 1, 32'h4);
      chk("ovf_clear_rd", read_data, 32'h87);
      step(1, 1, 1, 0, 32'd0);
      chk("ovf_cleared", read_data, 32'h83);
      drain("ovf");
      chk("ovf_frames", frames_done - base, 9);

      // Reset during the first data bit of 0x3C with two bytes queued behind it.
      base = frames_started;
      step(1, 1, 0, 1, 32'h3C);
      step(1, 1, 0, 1, 32'h11);
      step(1, 1, 0, 1, 32'h22);
      repeat (3) step(1, 0, 0, 0, 32'd0);
      chk("pre_reset_bit0", uart_tx, 0);
      do_reset();
      repeat (60) step(1, 0, 0, 0, 32'd0);
      step(1, 1, 1, 0, 32'd0);
      chk("post_reset_status", read_data, 32'h8);
      chk("post_reset_quiet", frames_started - base, 1);

      // Full FIFO with a pop on the same edge as a push.
      for (int i = 0; i < 9; i++) step(1, 1, 0, 1, $urandom);
      for (int g = 0; g < 200 && busy_left > 1; g++) step(1, 0, 0, 0, 32'd0);
      step(1, 1, 1, 0, 32'd0);
      chk("fullpop_pre", read_data, 32'h83);
      step(1, 1, 0, 1, $urandom);
      step(1, 1, 1, 0, 32'd0);
      chk("fullpop_post", read_data, 32'h83);
      drain("fullpop");

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         r_ce  = ($urandom_range(0, 3) != 0);
         r_sel = ($urandom_range(0, 4) != 0);
         r_rs  = ($urandom_range(0, 2) == 0);
         r_we  = ($urandom_range(0, 1) == 1);
         step(r_ce, r_sel, r_rs, r_we, $urandom);
      end
      drain("rand");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the MMIO side of the load/store path. The MMU encode stage suppresses RAM byte-enables when the address has the MMIO bit set; this block consumes those MMIO stores and serialises them 8N1 onto a TX pin. MMIO loads return a status word one enabled cycle later, matching RAM read latency. The decode stage therefore sees MMIO data at the same point in the pipeline as RAM data.

## Interface
Parameters:
- CLKS_PER_BIT, 104: clk cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 8: TX FIFO entries; must be a power of two, 2..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clk_enable  input  1  pipeline advance qualifier; gates the bus side only.
- mmio_sel  input  1  address MMIO bit of the stage-2 access.
- reg_sel  input  1  word select, addr[2]: 0 = TXDATA, 1 = STATUS.
- mem_we  input  1  stage-2 store strobe, from microcode mem_we.
- data_in  input  32  store data, unrotated; only [7:0] is used.
- read_data  output  32  registered read word, valid in the cycle after the enabled read.
- uart_tx  output  1  serial line; idles high.
- tx_irq  output  1  high while the FIFO is empty and the shifter is idle.

## Operation
Register map:
- TXDATA (reg_sel=0), write only.
  - A write pushes data_in[7:0] into the FIFO.
  - A read returns 0.
- STATUS (reg_sel=1), read/write.
  - Read layout: [0] busy (shifter not IDLE); [1] full; [2] overflow (sticky); [3] empty; [10:4] count (0..FIFO_DEPTH, zero-extended); [31:11] = 0.
  - Writing with data_in[2]=1 clears overflow. All other bits ignore writes.

Bus side (acts only when clk_enable=1):
- Push condition: mmio_sel & mem_we & ~reg_sel.
- Push is accepted if count < FIFO_DEPTH, or if a pop happens in the same cycle.
- Otherwise the byte is dropped and overflow is set.
- read_data <= status word or 0 on every enabled cycle with mmio_sel=1. It is loaded with 0 when mmio_sel=0.
- With clk_enable=0, read_data, the FIFO write pointer and overflow hold their values.

FIFO: circular buffer with wrapping read/write pointers and a separate count register (width clog2(FIFO_DEPTH)+1).

Shifter FSM (runs on every clk, independent of clk_enable):
- IDLE: uart_tx=1. If count>0, pop the head into shift_reg, clear baud_cnt and go to START.
- START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA: uart_tx=shift_reg[0], LSB first. At the end of each bit period, shift right and increment bit_idx. After bit 7, go to STOP.
- STOP: uart_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- baud_cnt counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.

## Timing
- Reset values:
  - read_data=0, uart_tx=1, tx_irq=1.
  - FSM=IDLE, count=0, pointers=0, overflow=0, baud_cnt=0, bit_idx=0.
- Reset mid-frame aborts the character immediately and uart_tx returns high asynchronously. FIFO contents are lost.
- Read latency: exactly one enabled cycle. A stalled read keeps its value until the next enabled edge.
- Push-to-line: a push at edge N makes count=1 after N. IDLE pops at edge N+1, and the start bit drives uart_tx from edge N+1.
- One frame takes 10*CLKS_PER_BIT cycles. A back-to-back FIFO entry starts one cycle after STOP ends (the IDLE pop cycle).
- Push and pop in the same edge: count is unchanged and both pointers advance.
- STATUS read in the same enabled cycle as a push returns the pre-push state.
- tx_irq = (count==0) & (FSM==IDLE), combinational from registers.

## Test plan
- Reset, then send nothing → uart_tx=1, tx_irq=1, STATUS read returns 0x0000_0008.
- CLKS_PER_BIT=4: write 0xA5 to TXDATA → after the push, uart_tx shows 0 (4 clk), then bits 1,0,1,0,0,1,0,1, then 1; frame is 40 clk and tx_irq rises afterward.
- FIFO_DEPTH=8 with the shifter held mid-frame: write 10 bytes back-to-back → 8 accepted, full=1, overflow=1, count=8. Write STATUS with 0x4 → overflow=0. Exactly 9 characters are transmitted (1 in flight + 8 queued).
- Hold clk_enable=0 while the store is presented → no push and read_data held. Raise clk_enable → push occurs once.
- Assert rst during the DATA state of 0x3C with 2 entries queued → uart_tx=1 immediately; after release, count=0 and there is no further line activity.
- FIFO full with a pop at the same edge as a push → push accepted, count stays 8, overflow stays 0; byte order is preserved across pointer wrap.
